// File: rtl/pp_shift_accumulator_if.sv
// Beat-in / result-out handshake bundle for the shifting partial-product accumulator.
interface pp_shift_accumulator_if #(
  parameter int unsigned SIZE    = 45,
  parameter int unsigned RADIX   = 54,
  parameter int unsigned SHIFT_W = 7,
  parameter int unsigned CNT_W   = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SIZE-1:0]      in_data;
  logic [SHIFT_W-1:0]   in_shift;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*RADIX-1:0]   out_data;
  logic                 out_ovf;
  logic [CNT_W-1:0]     out_beats;
  logic                 out_err;

  modport master (
    output in_valid, in_data, in_shift, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_beats, out_err
  );

  modport slave (
    input  in_valid, in_data, in_shift, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_beats, out_err
  );
endinterface

// File: rtl/pp_shift_accumulator.sv
// Accumulates shifted partial products one beat at a time and emits one 2*RADIX-bit sum per group,
// flagging bits lost to shift truncation or carry-out and groups force-closed at NUM_PP beats.
module pp_shift_accumulator #(
  parameter int unsigned SIZE    = 45,
  parameter int unsigned RADIX   = 54,
  parameter int unsigned NUM_PP  = 6,
  parameter int unsigned SHIFT_W = 7,
  parameter int unsigned CNT_W   = $clog2(NUM_PP + 1)
) (
  input logic                   clk,
  input logic                   rst,
  pp_shift_accumulator_if.slave bus
);

  localparam int unsigned AccW  = 2 * RADIX;
  // Wide enough that no in_data bit can be shifted off the top before truncation is detected.
  localparam int unsigned WideW = AccW + SIZE + (1 << SHIFT_W);

  typedef enum logic {StAcc, StHold} state_e;

  state_e             state_q, state_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [AccW-1:0]    data_q, data_d;
  logic               out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0]   beats_q, beats_d;
  logic               err_q, err_d;

  logic [WideW-1:0]   wide;
  logic [AccW-1:0]    shifted;
  logic               trunc_lost;
  logic [AccW:0]      sum;
  logic               accept;
  logic               last_slot;
  logic               close;
  logic               ovf_next;

  always_comb begin
    wide       = WideW'(bus.in_data) << bus.in_shift;
    shifted    = wide[AccW-1:0];
    trunc_lost = |wide[WideW-1:AccW];
    sum        = {1'b0, acc_q} + {1'b0, shifted};
    accept     = (state_q == StAcc) && bus.in_valid;
    last_slot  = (cnt_q == CNT_W'(NUM_PP - 1));
    close      = accept && (bus.in_last || last_slot);
    ovf_next   = ovf_q | trunc_lost | sum[AccW];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    data_d    = data_q;
    out_ovf_d = out_ovf_q;
    beats_d   = beats_q;
    err_d     = err_q;
    unique case (state_q)
      StAcc: begin
        if (accept) begin
          acc_d = sum[AccW-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_next;
          if (close) begin
            data_d    = sum[AccW-1:0];
            out_ovf_d = ovf_next;
            beats_d   = cnt_q + CNT_W'(1);
            // in_last on the final slot is a clean close, not an error.
            err_d     = ~bus.in_last;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAcc;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      out_ovf_q <= 1'b0;
      beats_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      data_q    <= data_d;
      out_ovf_q <= out_ovf_d;
      beats_q   <= beats_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_data  = data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_beats = beats_q;
  assign bus.out_err   = err_q;

endmodule
